// File: rtl/gray_ptr_fifo_ctrl.sv
// Push/pop sequencer for an 8-entry FIFO built on two external 8-state gray counters.
// Zero-latency increment gating; occupancy flags combinational from pointers and wrap bits; sticky errors.
module gray_ptr_fifo_ctrl #(
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic [4:0] wr_ptr,
  input  logic [4:0] rd_ptr,
  output logic       wr_inc,
  output logic       rd_inc,
  output logic       full,
  output logic       empty,
  output logic [3:0] level,
  output logic       almost_full,
  output logic       almost_empty,
  output logic       ovf_err,
  output logic       unf_err,
  output logic       ptr_err
);

  localparam logic [3:0] AF_LVL = AF_THRESH[3:0];
  localparam logic [3:0] AE_LVL = AE_THRESH[3:0];

  // Returns {illegal, index}; unknown codes land on index 7.
  function automatic logic [3:0] gray_decode(input logic [4:0] code);
    logic [3:0] r;
    case (code)
      5'b00000: r = 4'b0000;
      5'b00001: r = 4'b0001;
      5'b00011: r = 4'b0010;
      5'b00010: r = 4'b0011;
      5'b00110: r = 4'b0100;
      5'b00111: r = 4'b0101;
      5'b00101: r = 4'b0110;
      5'b00100: r = 4'b0111;
      default:  r = 4'b1111;
    endcase
    return r;
  endfunction

  logic [3:0] wr_dec;
  logic [3:0] rd_dec;
  logic [2:0] wr_idx;
  logic [2:0] rd_idx;
  logic       code_bad;
  logic       wr_wrap;
  logic       rd_wrap;
  logic       same_idx;

  assign wr_dec   = gray_decode(wr_ptr);
  assign rd_dec   = gray_decode(rd_ptr);
  assign wr_idx   = wr_dec[2:0];
  assign rd_idx   = rd_dec[2:0];
  assign code_bad = wr_dec[3] | rd_dec[3];

  assign same_idx = (wr_idx == rd_idx);
  assign full     = same_idx & (wr_wrap != rd_wrap);
  assign empty    = same_idx & (wr_wrap == rd_wrap);
  // 4-bit subtraction gives the mod-16 distance between the extended pointers.
  assign level    = {wr_wrap, wr_idx} - {rd_wrap, rd_idx};

  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

  assign wr_inc = reset_n & wr_req & ~full;
  assign rd_inc = reset_n & rd_req & ~empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_wrap <= 1'b0;
      rd_wrap <= 1'b0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
      ptr_err <= 1'b0;
    end else begin
      if (wr_inc && wr_idx == 3'd7) wr_wrap <= ~wr_wrap;
      if (rd_inc && rd_idx == 3'd7) rd_wrap <= ~rd_wrap;
      if (wr_req && full)  ovf_err <= 1'b1;
      if (rd_req && empty) unf_err <= 1'b1;
      if (code_bad)        ptr_err <= 1'b1;
    end
  end

endmodule
